// File: rtl/pwm_capture.sv
// PWM receiver: synchronises pwm_in, detects edges and measures period (rise to rise)
// and high time (rise to fall) in clk cycles, with timeout on a missing edge.
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_cycles,
  output logic [WIDTH-1:0] high_cycles,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_in;
  logic                   s_d;
  logic                   rise_det;
  logic                   fall_det;
  logic                   edge_det;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] high_lat;

  logic cnt_clr;
  logic cnt_ld;
  logic cnt_inc;
  logic hi_latch;
  logic publish;
  logic to_fire;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH'(1);
  endfunction

  // Front end: synchroniser chain plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
      s_d     <= s_in;
    end
  end

  assign s_in     = sync_p0[SYNC_STAGES-1];
  assign rise_det = s_in & ~s_d;
  assign fall_det = ~s_in & s_d;
  assign edge_det = rise_det | fall_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Disabling capture takes priority over every edge, so a partial measurement
  // in flight is abandoned rather than published.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_ld    = 1'b0;
    cnt_inc   = 1'b0;
    hi_latch  = 1'b0;
    publish   = 1'b0;
    to_fire   = 1'b0;
    if (!cap_en) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_det) begin
            cnt_ld    = 1'b1;
            state_nxt = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall_det) begin
            hi_latch  = 1'b1;
            cnt_inc   = 1'b1;
            state_nxt = MEAS_LOW;
          end else if (!edge_det && cnt == CNT_MAX) begin
            to_fire   = 1'b1;
            state_nxt = WAIT_RISE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          // An edge landing on the saturated count still counts as a valid period.
          if (rise_det) begin
            publish   = 1'b1;
            cnt_ld    = 1'b1;
            state_nxt = MEAS_HIGH;
          end else if (!edge_det && cnt == CNT_MAX) begin
            to_fire   = 1'b1;
            state_nxt = WAIT_RISE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // Counter stage: cnt equals cycles elapsed since the last detected rise
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      high_lat <= '0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_ld) begin
        cnt <= WIDTH'(1);
      end else if (cnt_inc) begin
        cnt <= sat_inc(cnt);
      end
      if (hi_latch) begin
        high_lat <= cnt;
      end
    end
  end

  // Output stage: registered results and one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cycles <= '0;
      high_cycles   <= '0;
      meas_valid    <= 1'b0;
      timeout       <= 1'b0;
      stuck_level   <= 1'b0;
    end else begin
      meas_valid <= publish;
      timeout    <= to_fire;
      if (publish) begin
        period_cycles <= cnt;
        high_cycles   <= high_lat;
      end
      if (to_fire) begin
        stuck_level <= s_in;
      end
    end
  end

  assign busy = (state == MEAS_HIGH) || (state == MEAS_LOW);

endmodule
